// File: rtl/enc_quad_ctrl.sv
// enc_quad_ctrl: multi-channel x4 quadrature decoder with debounced A/B/I
// inputs, per-channel preload, index latching and a snapshot-all capture.
//
// Ports:
//   sysclk, rstn            clock, asynchronous active-low reset
//   enc_a/enc_b/enc_i       raw encoder lines, bit k = channel k
//   reg_raddr_chan          channel selected onto the read buses
//   reg_waddr/wdata/wen     register write port (offset 4 preload, 5 mode)
//   snap_req / snap_done    capture all counts / completion pulse
//   reg_quad_data           {ovf, I, B, A, count}
//   reg_index_data          {index_cnt, index-latched count}
//   reg_snap_data           snapshot count
//   reg_status              {err_cnt, mode, idx_dir, last_dir, 24'd0}
//   enc_data                live counts, channel k at [k*CNT_W +: CNT_W]
module enc_quad_ctrl #(
  parameter int NUM_ENC = 4,
  parameter int CNT_W   = 24,
  parameter int DEB_CYC = 4
) (
  input  logic                     sysclk,
  input  logic                     rstn,
  input  logic [NUM_ENC-1:0]       enc_a,
  input  logic [NUM_ENC-1:0]       enc_b,
  input  logic [NUM_ENC-1:0]       enc_i,
  input  logic [3:0]               reg_raddr_chan,
  input  logic [15:0]              reg_waddr,
  input  logic [31:0]              reg_wdata,
  input  logic                     reg_wen,
  input  logic                     snap_req,
  output logic                     snap_done,
  output logic [31:0]              reg_quad_data,
  output logic [31:0]              reg_index_data,
  output logic [31:0]              reg_snap_data,
  output logic [31:0]              reg_status,
  output logic [NUM_ENC*CNT_W-1:0] enc_data
);

  localparam int NL     = 3 * NUM_ENC;
  // Decoding stays off until the filters have had time to pick up the
  // levels present at reset release, so static lines never look like steps.
  localparam int SETTLE = DEB_CYC + 3;
  localparam logic [CNT_W-1:0] CNT_RST = {1'b1, {(CNT_W-1){1'b0}}};

  logic [NL-1:0] raw_lines;
  assign raw_lines = {enc_i, enc_b, enc_a};

  logic [NL-1:0] sync1_q, sync2_q, filt_q, filt_d;
  logic [3:0]    deb_q [NL];
  logic [3:0]    deb_d [NL];
  logic [4:0]    settle_q, settle_d;

  logic [NUM_ENC-1:0] a_prev_q, a_prev_d, b_prev_q, b_prev_d, i_prev_q, i_prev_d;
  logic [NUM_ENC-1:0] pend_q, pend_d, ovf_q, ovf_d;
  logic [NUM_ENC-1:0] idx_dir_q, idx_dir_d, last_dir_q, last_dir_d;
  logic [CNT_W-1:0]   cnt_q  [NUM_ENC];
  logic [CNT_W-1:0]   cnt_d  [NUM_ENC];
  logic [CNT_W-1:0]   pre_q  [NUM_ENC];
  logic [CNT_W-1:0]   pre_d  [NUM_ENC];
  logic [CNT_W-1:0]   idat_q [NUM_ENC];
  logic [CNT_W-1:0]   idat_d [NUM_ENC];
  logic [CNT_W-1:0]   snap_q [NUM_ENC];
  logic [CNT_W-1:0]   snap_d [NUM_ENC];
  logic [3:0]         err_q  [NUM_ENC];
  logic [3:0]         err_d  [NUM_ENC];
  logic [3:0]         icnt_q [NUM_ENC];
  logic [3:0]         icnt_d [NUM_ENC];
  logic [1:0]         mode_q [NUM_ENC];
  logic [1:0]         mode_d [NUM_ENC];
  logic               snap_done_q, snap_done_d;

  // Debounce: flip the filtered level on the DEB_CYC-th consecutive
  // differing sample.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < NL; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == 4'(DEB_CYC - 1)) begin
        filt_d[i] = sync2_q[i];
        deb_d[i]  = '0;
      end else begin
        deb_d[i] = deb_q[i] + 4'd1;
      end
    end
    settle_d = (settle_q == 5'(SETTLE)) ? settle_q : settle_q + 5'd1;
  end

  logic wr_ok;
  assign wr_ok = reg_wen && (reg_waddr[15:12] == 4'h0);

  always_comb begin
    logic fa, fb, fi, a_chg, b_chg, legal, illegal, up, idx_ev, wsel, settled;
    settled     = (settle_q == 5'(SETTLE));
    snap_done_d = snap_req;
    a_prev_d    = filt_q[NUM_ENC-1:0];
    b_prev_d    = filt_q[2*NUM_ENC-1:NUM_ENC];
    i_prev_d    = filt_q[3*NUM_ENC-1:2*NUM_ENC];
    pend_d      = '0;
    ovf_d       = ovf_q;
    idx_dir_d   = idx_dir_q;
    last_dir_d  = last_dir_q;
    for (int unsigned k = 0; k < NUM_ENC; k++) begin
      cnt_d[k]  = cnt_q[k];
      pre_d[k]  = pre_q[k];
      idat_d[k] = idat_q[k];
      snap_d[k] = snap_req ? cnt_q[k] : snap_q[k];
      err_d[k]  = err_q[k];
      icnt_d[k] = icnt_q[k];
      mode_d[k] = mode_q[k];

      fa      = filt_q[k];
      fb      = filt_q[NUM_ENC + k];
      fi      = filt_q[2*NUM_ENC + k];
      a_chg   = fa ^ a_prev_q[k];
      b_chg   = fb ^ b_prev_q[k];
      legal   = settled & (a_chg ^ b_chg);
      illegal = settled & a_chg & b_chg;
      // A leads B: after an A edge A differs from B, after a B edge they match.
      up      = a_chg ? (fa ^ fb) : ~(fa ^ fb);
      idx_ev  = settled & fi & ~i_prev_q[k] & (mode_q[k] != 2'd0);
      wsel    = wr_ok && (reg_waddr[7:4] == 4'(k));

      if (wsel && reg_waddr[3:0] == 4'h4) begin
        pre_d[k]  = reg_wdata[CNT_W-1:0];
        pend_d[k] = 1'b1;
      end
      if (wsel && reg_waddr[3:0] == 4'h5) mode_d[k] = reg_wdata[1:0];

      if (idx_ev) begin
        idat_d[k]    = cnt_q[k];
        idx_dir_d[k] = last_dir_q[k];
        icnt_d[k]    = icnt_q[k] + 4'd1;
      end
      if (legal) last_dir_d[k] = up;

      // Count priority: pending preload, then index zero, then step.
      if (pend_q[k]) begin
        cnt_d[k] = pre_q[k];
        ovf_d[k] = 1'b0;
        err_d[k] = '0;
      end else begin
        if (illegal && err_q[k] != 4'hF) err_d[k] = err_q[k] + 4'd1;
        if (idx_ev && mode_q[k] == 2'd2) begin
          cnt_d[k] = '0;
        end else if (legal) begin
          if (up) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
            if (cnt_q[k] == '1) ovf_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] - CNT_W'(1);
            if (cnt_q[k] == '0) ovf_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      settle_q    <= '0;
      a_prev_q    <= '0;
      b_prev_q    <= '0;
      i_prev_q    <= '0;
      pend_q      <= '0;
      ovf_q       <= '0;
      idx_dir_q   <= '0;
      last_dir_q  <= '0;
      snap_done_q <= 1'b0;
      for (int unsigned i = 0; i < NL; i++) deb_q[i] <= '0;
      for (int unsigned k = 0; k < NUM_ENC; k++) begin
        cnt_q[k]  <= CNT_RST;
        pre_q[k]  <= CNT_RST;
        idat_q[k] <= '0;
        snap_q[k] <= '0;
        err_q[k]  <= '0;
        icnt_q[k] <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      sync1_q     <= raw_lines;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      settle_q    <= settle_d;
      a_prev_q    <= a_prev_d;
      b_prev_q    <= b_prev_d;
      i_prev_q    <= i_prev_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      idx_dir_q   <= idx_dir_d;
      last_dir_q  <= last_dir_d;
      snap_done_q <= snap_done_d;
      for (int unsigned i = 0; i < NL; i++) deb_q[i] <= deb_d[i];
      for (int unsigned k = 0; k < NUM_ENC; k++) begin
        cnt_q[k]  <= cnt_d[k];
        pre_q[k]  <= pre_d[k];
        idat_q[k] <= idat_d[k];
        snap_q[k] <= snap_d[k];
        err_q[k]  <= err_d[k];
        icnt_q[k] <= icnt_d[k];
        mode_q[k] <= mode_d[k];
      end
    end
  end

  assign snap_done = snap_done_q;

  always_comb begin
    reg_quad_data  = '0;
    reg_index_data = '0;
    reg_snap_data  = '0;
    reg_status     = '0;
    enc_data       = '0;
    for (int unsigned k = 0; k < NUM_ENC; k++) begin
      enc_data[k*CNT_W +: CNT_W] = cnt_q[k];
      if (reg_raddr_chan == 4'(k)) begin
        reg_quad_data  = {ovf_q[k], filt_q[2*NUM_ENC + k], filt_q[NUM_ENC + k],
                          filt_q[k], 28'(cnt_q[k])};
        reg_index_data = {icnt_q[k], 28'(idat_q[k])};
        reg_snap_data  = 32'(snap_q[k]);
        reg_status     = {err_q[k], mode_q[k], idx_dir_q[k], last_dir_q[k], 24'd0};
      end
    end
  end

endmodule
